// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline-stage register for the 16-bit MIPS pipeline (ID/EX, EX/MEM, MEM/WB).
// Optional 2-entry skid buffer, synchronous flush, bubble insertion and a saturating stall counter.
module pipe_stage_reg #(
    parameter int unsigned              DATA_W      = 64,
    parameter int unsigned              CTRL_W      = 14,
    parameter logic [CTRL_W-1:0]        CTRL_BUBBLE = '0,
    parameter int unsigned              SKID        = 1,
    parameter int unsigned              CNT_W       = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [1:0]        occupancy
);

    localparam logic [1:0] StEmpty = 2'd0;
    localparam logic [1:0] StOne   = 2'd1;
    localparam logic [1:0] StTwo   = 2'd2;

    localparam logic [CNT_W-1:0] CntMax = '1;

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic              in_ready_q, in_ready_d;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic              in_xfer, out_xfer;

    assign out_valid = (state_q != StEmpty);
    assign in_ready  = (SKID != 0) ? in_ready_q : (!out_valid || out_ready);
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;

    assign out_data  = main_data_q;
    assign out_ctrl  = out_valid ? main_ctrl_q : CTRL_BUBBLE;
    assign stall_cnt = stall_q;
    assign occupancy = state_q;

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;
        case (state_q)
            StEmpty: begin
                if (in_xfer) begin
                    state_d     = StOne;
                    main_data_d = in_data;
                    main_ctrl_d = in_ctrl;
                end
            end
            StOne: begin
                if (in_xfer && out_xfer) begin
                    main_data_d = in_data;
                    main_ctrl_d = in_ctrl;
                end else if (in_xfer) begin
                    // Only reachable with the skid buffer; without it in_ready implies out_ready.
                    state_d     = StTwo;
                    skid_data_d = in_data;
                    skid_ctrl_d = in_ctrl;
                end else if (out_xfer) begin
                    state_d = StEmpty;
                end
            end
            StTwo: begin
                if (out_xfer) begin
                    state_d     = StOne;
                    main_data_d = skid_data_q;
                    main_ctrl_d = skid_ctrl_q;
                end
            end
            default: state_d = StEmpty;
        endcase
        if (flush) begin
            state_d = StEmpty;
        end
    end

    assign in_ready_d = (state_d != StTwo);

    // Stalls are counted regardless of flush; only reset clears the counter.
    always_comb begin
        stall_d = stall_q;
        if (out_valid && !out_ready && (stall_q != CntMax)) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StEmpty;
            main_data_q <= '0;
            main_ctrl_q <= CTRL_BUBBLE;
            skid_data_q <= '0;
            skid_ctrl_q <= CTRL_BUBBLE;
            in_ready_q  <= 1'b1;
            stall_q     <= '0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            in_ready_q  <= in_ready_d;
            stall_q     <= stall_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: three instances (skid, no-skid, 4-bit counter) checked by a FIFO
// scoreboard whose reference is a plain queue with capacity and flush rules.
module tb_pipe_stage_reg;

    typedef logic [77:0] ent_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        in_valid  [3];
    logic        in_ready  [3];
    logic [63:0] in_data   [3];
    logic [13:0] in_ctrl   [3];
    logic        out_valid [3];
    logic        out_ready [3];
    logic [63:0] out_data  [3];
    logic [13:0] out_ctrl  [3];
    logic [7:0]  stall_cnt [3];
    logic [1:0]  occ       [3];
    logic        flush     [3];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : gen_dut
        localparam int unsigned SK = (g == 1) ? 0 : 1;
        localparam int unsigned CW = (g == 2) ? 4 : 8;

        logic [CW-1:0] sc;
        ent_t          exp_q[$];
        int            exp_stall = 0;

        pipe_stage_reg #(
            .DATA_W (64),
            .CTRL_W (14),
            .SKID   (SK),
            .CNT_W  (CW)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .flush     (flush[g]),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_data   (in_data[g]),
            .in_ctrl   (in_ctrl[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_data  (out_data[g]),
            .out_ctrl  (out_ctrl[g]),
            .stall_cnt (sc),
            .occupancy (occ[g])
        );
        assign stall_cnt[g] = 8'(sc);

        // Stimulus side: record each accepted entry; flush discards everything held.
        initial forever begin
            @(negedge clk);
            if (rst_n) begin
                logic acc, fl;
                ent_t e;
                acc = in_valid[g] && in_ready[g];
                fl  = flush[g];
                e   = {in_data[g], in_ctrl[g]};
                #1;
                if (fl) exp_q.delete();
                else if (acc) exp_q.push_back(e);
            end
        end

        // Monitor: compare the DUT against the queue model, pop on each output transfer.
        initial forever begin
            @(negedge clk);
            if (rst_n) begin
                int n;
                logic exp_v, exp_rdy;
                n       = exp_q.size();
                exp_v   = (n != 0);
                exp_rdy = (SK != 0) ? (n != 2) : (n == 0 || out_ready[g]);
                chk($sformatf("d%0d out_valid", g), out_valid[g], exp_v);
                chk($sformatf("d%0d in_ready", g), in_ready[g], exp_rdy);
                chk($sformatf("d%0d occupancy", g), occ[g], n);
                chk($sformatf("d%0d stall_cnt", g), stall_cnt[g], exp_stall);
                if (exp_v) chk($sformatf("d%0d entry", g), {out_data[g], out_ctrl[g]}, exp_q[0]);
                else chk($sformatf("d%0d bubble", g), out_ctrl[g], 14'h0);
                if (exp_v && !out_ready[g] && exp_stall < (1 << CW) - 1) exp_stall++;
                if (exp_v && out_ready[g]) void'(exp_q.pop_front());
            end
        end

        initial forever begin
            @(negedge rst_n);
            exp_q.delete();
            exp_stall = 0;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Holds the entry stable until accepted, as upstream must.
    task automatic send(input int d, input logic [63:0] dat, input logic [13:0] ctl);
        logic done = 1'b0;
        in_valid[d] = 1'b1;
        in_data[d]  = dat;
        in_ctrl[d]  = ctl;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            done = in_ready[d];
            @(posedge clk);
            #1;
        end
        in_valid[d] = 1'b0;
        chk($sformatf("d%0d send accepted", d), done, 1'b1);
    endtask

    task automatic chk_reset(input int d);
        chk($sformatf("d%0d rst out_valid", d), out_valid[d], 1'b0);
        chk($sformatf("d%0d rst out_data", d), out_data[d], 64'h0);
        chk($sformatf("d%0d rst out_ctrl", d), out_ctrl[d], 14'h0);
        chk($sformatf("d%0d rst stall_cnt", d), stall_cnt[d], 8'h0);
        chk($sformatf("d%0d rst occupancy", d), occ[d], 2'd0);
        chk($sformatf("d%0d rst in_ready", d), in_ready[d], 1'b1);
    endtask

    task automatic rand_run(input int d, input int n, input logic fl_en);
        logic pdone = 1'b0;
        fork
            begin
                for (int i = 0; i < n; i++) begin
                    step($urandom_range(0, 2));
                    send(d, {$urandom, $urandom}, 14'($urandom));
                end
                pdone = 1'b1;
            end
            begin
                while (!pdone) begin
                    out_ready[d] = ($urandom_range(0, 3) != 0);
                    flush[d]     = fl_en && ($urandom_range(0, 15) == 0);
                    step(1);
                end
                out_ready[d] = 1'b1;
                flush[d]     = 1'b0;
            end
        join
        step(4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b1;
        for (int d = 0; d < 3; d++) begin
            in_valid[d] = 1'b0; in_data[d] = '0; in_ctrl[d] = '0;
            out_ready[d] = 1'b0; flush[d] = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) chk_reset(d);
        @(posedge clk);
        #4 rst_n = 1'b1;
        step(1);

        // Single entry appears one edge after acceptance.
        out_ready[0] = 1'b1;
        send(0, 64'h0002_1234_0005_FFFE, 14'h2A5);
        chk("t1 out_valid", out_valid[0], 1'b1);
        chk("t1 out_data", out_data[0], 64'h0002_1234_0005_FFFE);
        chk("t1 out_ctrl", out_ctrl[0], 14'h2A5);
        chk("t1 occupancy", occ[0], 2'd1);
        step(2);

        // Stall fills the skid register; order preserved on release.
        out_ready[0] = 1'b1;
        send(0, 64'hD0D0_0000_0000_0000, 14'h001);
        out_ready[0] = 1'b0;
        send(0, 64'hD1D1_0000_0000_0001, 14'h002);
        chk("t2 occupancy", occ[0], 2'd2);
        chk("t2 in_ready", in_ready[0], 1'b0);
        fork
            begin
                send(0, 64'hD2D2_0000_0000_0002, 14'h003);
                send(0, 64'hD3D3_0000_0000_0003, 14'h004);
            end
            begin
                step(5);
                out_ready[0] = 1'b1;
            end
        join
        step(4);
        chk("t2 drained", occ[0], 2'd0);

        // Flush while full with an incoming entry.
        out_ready[0] = 1'b0;
        send(0, 64'hAAAA_0000_0000_0001, 14'h011);
        send(0, 64'hAAAA_0000_0000_0002, 14'h012);
        in_valid[0] = 1'b1; in_data[0] = 64'hBAD0_0000_0000_0003; in_ctrl[0] = 14'h3FF;
        flush[0] = 1'b1;
        step(1);
        flush[0] = 1'b0; in_valid[0] = 1'b0;
        chk("t3 out_valid", out_valid[0], 1'b0);
        chk("t3 out_ctrl", out_ctrl[0], 14'h0);
        chk("t3 in_ready", in_ready[0], 1'b1);
        chk("t3 occupancy", occ[0], 2'd0);
        // Flush at occupancy 1 while an input transfers: that input is discarded too.
        send(0, 64'hAAAA_0000_0000_0004, 14'h014);
        in_valid[0] = 1'b1; in_data[0] = 64'hBAD0_0000_0000_0005; in_ctrl[0] = 14'h3FE;
        flush[0] = 1'b1;
        step(1);
        flush[0] = 1'b0; in_valid[0] = 1'b0;
        out_ready[0] = 1'b1;
        step(2);
        chk("t3b out_valid", out_valid[0], 1'b0);

        // Without the skid buffer in_ready follows out_ready combinationally.
        out_ready[1] = 1'b0;
        send(1, 64'h1111_2222_3333_4444, 14'h155);
        chk("t4 out_valid", out_valid[1], 1'b1);
        chk("t4 in_ready stalled", in_ready[1], 1'b0);
        out_ready[1] = 1'b1;
        #1 chk("t4 in_ready follows 1", in_ready[1], 1'b1);
        out_ready[1] = 1'b0;
        #1 chk("t4 in_ready follows 0", in_ready[1], 1'b0);
        out_ready[1] = 1'b1;
        #1 chk("t4 in_ready follows 1b", in_ready[1], 1'b1);
        step(1);
        rand_run(1, 10, 1'b0);
        chk("t4 empty after stream", occ[1], 2'd0);

        // 4-bit stall counter saturates and survives flush.
        out_ready[2] = 1'b0;
        send(2, 64'h5555_0000_0000_0005, 14'h055);
        step(20);
        chk("t5 saturated", stall_cnt[2], 8'd15);
        flush[2] = 1'b1;
        step(1);
        flush[2] = 1'b0;
        step(3);
        chk("t5 after flush", stall_cnt[2], 8'd15);

        // Asynchronous reset while full.
        out_ready[0] = 1'b0;
        send(0, 64'h6666_0000_0000_0001, 14'h061);
        send(0, 64'h6666_0000_0000_0002, 14'h062);
        chk("t6 full", occ[0], 2'd2);
        #1 rst_n = 1'b0;
        #1;
        chk_reset(0);
        chk_reset(2);
        #1 rst_n = 1'b1;
        step(1);

        fork
            rand_run(0, 40, 1'b1);
            rand_run(1, 40, 1'b1);
            rand_run(2, 40, 1'b1);
        join
        step(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
